// File: rtl/pe_cluster_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_cluster_pkg
// Description : Shared types, default sizes and the requantisation helper for
//               the PE cluster streaming engine.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_cluster_pkg;

    localparam int c_def_num_pe = 16;
    localparam int c_def_lanes  = 4;
    localparam int c_def_acc_w  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Round-half-up arithmetic shift, saturate to int8, optional ReLU.
    // The accumulator arrives sign-extended to 64 bits so the rounding add
    // can never overflow.
    function automatic logic [7:0] requant(input logic signed [63:0] acc,
                                           input logic [4:0]         shift,
                                           input logic               relu_en);
        logic signed [63:0] r;
        r = acc;
        if (shift != 5'd0) begin
            r = r + (64'sd1 <<< (shift - 5'd1));
        end
        r = r >>> shift;
        if (r > 64'sd127) begin
            r = 64'sd127;
        end else if (r < -64'sd128) begin
            r = -64'sd128;
        end
        if (relu_en && (r < 64'sd0)) begin
            r = 64'sd0;
        end
        return r[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : pe_mac_unit
// Description : One processing element: LANES-wide signed int8 dot product
//               feeding a wrapping signed accumulator with clear and enable.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_mac_unit #(
    parameter int LANES = 4,
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic [LANES*8-1:0]      i_ifm_data,
    input  logic [LANES*8-1:0]      i_weight,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_dot;

    // Dot product of this beat, truncated to the accumulator width (wraps).
    always_comb begin
        w_dot = '0;
        for (int i = 0; i < LANES; i++) begin
            w_dot = w_dot + ACC_W'($signed(i_ifm_data[i*8 +: 8]) *
                                   $signed(i_weight[i*8 +: 8]));
        end
    end

    // Accumulator: clear on job start, add on every accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_dot;
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/pe_cluster_stream.sv
`default_nettype none
// ============================================================================
// Module      : pe_cluster_stream
// Description : Cluster of NUM_PE MAC units sharing one IFM broadcast stream.
//               Accumulates k_len beats, then drains requantised int8 results
//               of the enabled PEs in ascending index order.
// Revision    : 1.0 - initial release
// ============================================================================
import pe_cluster_pkg::*;

module pe_cluster_stream #(
    parameter int NUM_PE = c_def_num_pe,
    parameter int LANES  = c_def_lanes,
    parameter int ACC_W  = c_def_acc_w
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [15:0]                 k_len,
    input  logic [NUM_PE-1:0]           pe_en,
    input  logic [4:0]                  shift,
    input  logic                        relu_en,
    input  logic [LANES*8-1:0]          ifm_data,
    input  logic                        ifm_valid,
    output logic                        ifm_ready,
    input  logic [NUM_PE*LANES*8-1:0]   weight,
    output logic [7:0]                  out_data,
    output logic [$clog2(NUM_PE)-1:0]   out_idx,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int c_idx_w = $clog2(NUM_PE);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [15:0]             r_cnt;
    logic [15:0]             r_k_len;
    logic [NUM_PE-1:0]       r_pe_en;
    logic [NUM_PE-1:0]       r_remain;
    logic [4:0]              r_shift;
    logic                    r_relu;

    logic                    w_start_job;
    logic                    w_accept;
    logic                    w_last_beat;
    logic                    w_any;
    logic                    w_take;
    logic [c_idx_w-1:0]      w_idx;
    logic signed [ACC_W-1:0] w_acc [NUM_PE];
    logic signed [ACC_W-1:0] w_acc_sel;

    assign w_start_job = (r_state == IDLE) && start;
    assign w_accept    = (r_state == ACCUM) && ifm_valid;
    assign w_last_beat = w_accept && ((r_cnt + 16'd1) == r_k_len);
    assign w_any       = |r_remain;
    assign w_take      = (r_state == DRAIN) && w_any && out_ready;

    generate
        for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
            pe_mac_unit #(
                .LANES (LANES),
                .ACC_W (ACC_W)
            ) u_mac (
                .clk        (clk),
                .rst        (reset_n),
                .i_clr      (w_start_job),
                .i_en       (w_accept && r_pe_en[p]),
                .i_ifm_data (ifm_data),
                .i_weight   (weight[p*LANES*8 +: LANES*8]),
                .o_acc      (w_acc[p])
            );
        end
    endgenerate

    // Lowest-indexed PE still waiting to be drained; gives bubble-free skipping.
    always_comb begin
        w_idx = '0;
        for (int p = NUM_PE - 1; p >= 0; p--) begin
            if (r_remain[p]) begin
                w_idx = c_idx_w'(p);
            end
        end
    end

    assign w_acc_sel = w_acc[w_idx];

    // State register.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        w_state_nxt = r_state;
        ifm_ready   = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = (k_len == 16'd0) ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                ifm_ready = 1'b1;
                if (w_last_beat) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = w_any;
                if (!w_any) begin
                    done        = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Job configuration, beat counter and drain bookkeeping.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_cnt    <= '0;
            r_k_len  <= '0;
            r_pe_en  <= '0;
            r_remain <= '0;
            r_shift  <= '0;
            r_relu   <= 1'b0;
        end else begin
            if (w_start_job) begin
                r_cnt    <= '0;
                r_k_len  <= k_len;
                r_pe_en  <= pe_en;
                r_remain <= pe_en;
                r_shift  <= shift;
                r_relu   <= relu_en;
            end
            if (w_accept) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_take) begin
                r_remain[w_idx] <= 1'b0;
            end
        end
    end

    // Result path is combinational off the held accumulators, so it stays
    // stable for as long as the downstream stalls.
    assign out_data = out_valid ? requant(64'(w_acc_sel), r_shift, r_relu) : 8'd0;
    assign out_idx  = out_valid ? w_idx : '0;

endmodule
`default_nettype wire

// File: tb/tb_pe_cluster_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_cluster_stream
// Description : Directed self-checking bench for pe_cluster_stream with a
//               scoreboard of expected drain results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_cluster_stream;

    localparam int NUM_PE = 16;
    localparam int LANES  = 4;
    localparam int ACC_W  = 24;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      start;
    logic [15:0]               k_len;
    logic [NUM_PE-1:0]         pe_en;
    logic [4:0]                shift;
    logic                      relu_en;
    logic [LANES*8-1:0]        ifm_data;
    logic                      ifm_valid;
    logic                      ifm_ready;
    logic [NUM_PE*LANES*8-1:0] weight;
    logic [7:0]                out_data;
    logic [3:0]                out_idx;
    logic                      out_valid;
    logic                      out_ready;
    logic                      busy;
    logic                      done;

    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] data;
    } exp_t;

    exp_t                    sb[$];
    exp_t                    e_mon;
    int                      checks   = 0;
    int                      failures = 0;
    int                      done_cnt = 0;
    logic signed [ACC_W-1:0] macc [NUM_PE];

    always #5 clk = ~clk;

    pe_cluster_stream #(
        .NUM_PE (NUM_PE),
        .LANES  (LANES),
        .ACC_W  (ACC_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .k_len     (k_len),
        .pe_en     (pe_en),
        .shift     (shift),
        .relu_en   (relu_en),
        .ifm_data  (ifm_data),
        .ifm_valid (ifm_valid),
        .ifm_ready (ifm_ready),
        .weight    (weight),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_q(input logic signed [ACC_W-1:0] a,
                                         input logic [4:0] sh, input logic rl);
        longint r;
        r = longint'(a);
        if (sh != 5'd0) r = r + (longint'(1) << (sh - 5'd1));
        r = r >>> sh;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        if (rl && r < 0) r = 0;
        return r[7:0];
    endfunction

    function automatic logic [7:0] ifm_byte(input int mode);
        case (mode)
            0:       return 8'd1;
            1:       return 8'd10;
            2:       return 8'd25;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [7:0] w_byte(input int mode, input int p);
        case (mode)
            0:       return 8'd2;
            1:       return 8'd10;
            2:       return (p < 8) ? 8'd10 : 8'hF6;
            default: return 8'($urandom);
        endcase
    endfunction

    // Scoreboard: compare every accepted result and count done pulses.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", {24'd0, out_data}, 32'h100);
            end else begin
                e_mon = sb.pop_front();
                check("out_idx", {28'd0, out_idx}, {28'd0, e_mon.idx});
                check("out_data", {24'd0, out_data}, {24'd0, e_mon.data});
            end
        end
        if (done) done_cnt++;
    end

    task automatic run_job(input int k, input logic [15:0] en, input logic [4:0] sh,
                           input logic rl, input int mode, input bit gaps,
                           input bit hold_first, input bit start_in_drain,
                           input int abort_beat);
        int  d0;
        int  b;
        int  cyc;
        bit  v;
        logic [LANES*8-1:0]        v_ifm;
        logic [NUM_PE*LANES*8-1:0] v_w;
        d0  = done_cnt;
        b   = 0;
        cyc = 0;
        v   = 1'b1;
        for (int p = 0; p < NUM_PE; p++) macc[p] = '0;
        out_ready = !hold_first;
        k_len   = 16'(k);
        pe_en   = en;
        shift   = sh;
        relu_en = rl;
        start   = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        while (b < k && cyc < 200) begin
            for (int i = 0; i < LANES; i++) v_ifm[i*8 +: 8] = ifm_byte(mode);
            for (int p = 0; p < NUM_PE; p++)
                for (int i = 0; i < LANES; i++)
                    v_w[(p*LANES+i)*8 +: 8] = w_byte(mode, p);
            ifm_data  = v_ifm;
            weight    = v_w;
            ifm_valid = gaps ? v : 1'b1;
            v = !v;
            if (b == abort_beat && ifm_valid) begin
                reset_n = 1'b1;
            end else if (ifm_valid && ifm_ready) begin
                for (int p = 0; p < NUM_PE; p++) begin
                    if (en[p]) begin
                        int dot;
                        dot = 0;
                        for (int i = 0; i < LANES; i++)
                            dot += int'($signed(v_ifm[i*8 +: 8])) *
                                   int'($signed(v_w[(p*LANES+i)*8 +: 8]));
                        macc[p] = macc[p] + ACC_W'(dot);
                    end
                end
                b++;
            end
            step();
            cyc++;
            if (reset_n) begin
                reset_n   = 1'b0;
                ifm_valid = 1'b0;
                check("abort_busy", {31'd0, busy}, 32'd0);
                check("abort_ifm_ready", {31'd0, ifm_ready}, 32'd0);
                check("abort_out_valid", {31'd0, out_valid}, 32'd0);
                repeat (5) step();
                check("abort_no_done", done_cnt, d0);
                return;
            end
        end
        ifm_valid = 1'b0;
        check("beats_accepted", b, k);
        check("ifm_ready_after_last", {31'd0, ifm_ready}, 32'd0);
        for (int p = 0; p < NUM_PE; p++)
            if (en[p]) sb.push_back('{idx: 4'(p), data: exp_q(macc[p], sh, rl)});
        if (hold_first) begin
            repeat (3) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_idx", {28'd0, out_idx}, {28'd0, sb[0].idx});
                check("hold_data", {24'd0, out_data}, {24'd0, sb[0].data});
                step();
            end
            out_ready = 1'b1;
        end
        for (int c = 0; c < 300 && done_cnt == d0; c++) begin
            start = start_in_drain && (c == 0);
            step();
        end
        start = 1'b0;
        check("done_seen", done_cnt, d0 + 1);
        repeat (2) step();
        check("done_single", done_cnt, d0 + 1);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        reset_n   = 1'b1;
        start     = 1'b0;
        k_len     = '0;
        pe_en     = '0;
        shift     = '0;
        relu_en   = 1'b0;
        ifm_data  = '0;
        ifm_valid = 1'b0;
        weight    = '0;
        out_ready = 1'b1;
        repeat (3) step();
        check("rst_ifm_ready", {31'd0, ifm_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_idx", {28'd0, out_idx}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset_n = 1'b0;
        step();

        // k=1, ifm 1, weights 2 -> 8 from every PE
        run_job(1, 16'hFFFF, 5'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
        // k=3, all 10, shift 4 -> 75
        run_job(3, 16'hFFFF, 5'd4, 1'b0, 1, 1'b0, 1'b0, 1'b0, -1);
        // +/-1000 saturation, then with ReLU
        run_job(1, 16'hFFFF, 5'd0, 1'b0, 2, 1'b0, 1'b0, 1'b0, -1);
        run_job(1, 16'hFFFF, 5'd0, 1'b1, 2, 1'b0, 1'b0, 1'b0, -1);
        // sparse mask with a stalled first result
        run_job(1, 16'h8001, 5'd0, 1'b0, 0, 1'b0, 1'b1, 1'b0, -1);
        // gapped stream with random data
        run_job(4, 16'hFFFF, 5'd9, 1'b0, 3, 1'b1, 1'b0, 1'b0, -1);
        // reset during the third accepted beat, then a clean job
        run_job(4, 16'hFFFF, 5'd9, 1'b0, 3, 1'b1, 1'b0, 1'b0, 2);
        run_job(4, 16'hFFFF, 5'd9, 1'b0, 3, 1'b1, 1'b0, 1'b0, -1);
        // random mask, ReLU on
        run_job(2, 16'($urandom), 5'd6, 1'b1, 3, 1'b0, 1'b0, 1'b0, -1);
        // empty job, start pulsed while draining
        run_job(0, 16'hFFFF, 5'd0, 1'b0, 0, 1'b0, 1'b0, 1'b1, -1);
        // empty mask: done on the first drain cycle
        run_job(0, 16'h0000, 5'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pe_cluster_stream.md
PE_CLUSTER_STREAM -- requirements
Module: pe_cluster_stream

Interface
REQ-001 Parameter NUM_PE, default 16, number of processing elements; all PEs share one IFM broadcast.
REQ-002 Parameter LANES, default 4, 8-bit MAC lanes per PE.
REQ-003 Parameter ACC_W, default 24, signed accumulator width per PE.
REQ-004 Ports:
- clk  in  1  clock; single clock domain.
- reset_n  in  1  synchronous, active-high reset; despite the suffix, reset is asserted when reset_n=1.
- start  in  1  begins a job; sampled only in IDLE.
- k_len  in  16  IFM beats per job; latched on start.
- pe_en  in  NUM_PE  per-PE enable mask; latched on start.
- shift  in  5  requant right-shift, 0..ACC_W-1; latched on start.
- relu_en  in  1  clamp negatives to 0; latched on start.
- ifm_data  in  LANES*8  signed IFM bytes; lane i is bits [8i+7:8i].
- ifm_valid  in  1  IFM beat valid.
- ifm_ready  out  1  IFM beat accepted.
- weight  in  NUM_PE*LANES*8  signed weights; PE p lane i is bits [(p*LANES+i)*8 +: 8]; sampled with each accepted beat.
- out_data  out  8  requantized signed result.
- out_idx  out  $clog2(NUM_PE)  PE index of out_data.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse at job end.

Function
REQ-005 FSM states: IDLE, ACCUM, DRAIN.
REQ-006 IDLE, start=1: latch config, clear all accumulators; go to ACCUM, or to DRAIN if k_len=0.
REQ-007 start outside IDLE is ignored.
REQ-008 ifm_ready=1 exactly when state=ACCUM.
REQ-009 Accepted beat (ifm_valid&&ifm_ready): each enabled PE p adds sum over i of ifm_data[i]*weight[p][i] to acc[p]. The add is signed, full precision, wraps modulo 2^ACC_W. The result is visible the next cycle.
REQ-010 Disabled PEs hold acc at 0.
REQ-011 Beat counter increments per accepted beat. On the beat that makes it equal k_len, the next state is DRAIN; no further beats are accepted.
REQ-012 ifm_valid gaps stall the job without changing acc or the counter.
REQ-013 DRAIN presents enabled PEs in ascending index order, skipping disabled PEs with no bubble cycles. The first result is valid in the first DRAIN cycle.
REQ-014 Each DRAIN result is held until out_ready: out_valid, out_data and out_idx stay stable while out_valid&&!out_ready.
REQ-015 After the last enabled PE is accepted: done=1 for one cycle, state=IDLE the next cycle.
REQ-016 pe_en=0 at start: DRAIN emits nothing; done pulses on the first DRAIN cycle.
REQ-017 Requant:
- r = acc, or acc + (1<<(shift-1)) when shift>0;
- r >>>= shift (arithmetic);
- saturate to [-128,127];
- if relu_en and r<0, r=0.
REQ-018 out_valid=0 outside DRAIN.

Reset
REQ-019 When reset_n=1 at a clock edge: state=IDLE, all acc=0, counter=0, latched config=0.
REQ-020 Outputs under reset: ifm_ready=0, out_valid=0, out_data=0, out_idx=0, busy=0, done=0.
REQ-021 Reset asserted mid-ACCUM or mid-DRAIN aborts the job; no done pulse is produced.

Structure
REQ-022 Package pe_cluster_pkg holds the state enum, the requant function, and the default parameter constants.
REQ-023 Sub-module pe_mac_unit implements one PE (LANES-wide dot product plus accumulator with clear/enable); it is instantiated NUM_PE times via generate.

Verification
REQ-024 Defaults; k_len=1; ifm all 1; weights all 2; shift=0; pe_en=FFFF -> 16 results of 8, idx 0..15, then one done pulse.
REQ-025 k_len=3; ifm and weights all 10; shift=4 -> every result (1200+8)>>>4=75.
REQ-026 Saturation: acc=1000, shift=0 -> 127; acc=-1000 -> -128 with relu_en=0 and 0 with relu_en=1.
REQ-027 pe_en=16'h8001 with out_ready low for 3 cycles on the first result -> idx 0 held stable 3 cycles, then idx 15, then done; no other idx appears.
REQ-028 k_len=4 with ifm_valid toggling 1010... -> job completes after 4 accepted beats with correct sums; reset asserted during the 3rd beat -> IDLE, busy=0, no done, next job from start correct.
REQ-029 k_len=0 with pe_en=FFFF -> 16 results of 0; start pulsed during DRAIN has no effect.
